// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: host handshake and SPI bus signals of spi_master_ctrl
interface spi_master_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  modport master (
    input  tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );
  modport slave (
    output tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master, one byte per accepted request, MSB first
module spi_master_ctrl #(
  parameter int DIV = 2
) (
  input logic              clk,
  input logic              rst,
  spi_master_ctrl_if.master bus
);
  localparam int W = $clog2(DIV) + 1;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_div_cnt;
  logic [2:0]     r_bit_cnt;
  logic [6:0]     r_tx_shift;
  logic [7:0]     r_rx_shift;
  logic [7:0]     r_rx_data;
  logic           r_sclk;
  logic           r_mosi;
  logic           r_cs_n;
  logic           r_rx_valid;
  logic           w_tc;
  logic           w_last;
  if (DIV < 1) begin : g_div_check
    $fatal(1, "spi_master_ctrl: DIV must be >= 1");
  end
  assign w_tc   = r_div_cnt == W'(DIV - 1);
  assign w_last = w_tc && r_sclk && r_bit_cnt == 3'd7;
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // next-state: SETUP and HOLD last DIV cycles, XFER ends on the eighth falling sclk
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.tx_valid ? SETUP : IDLE;
      SETUP:   w_next = w_tc ? XFER : SETUP;
      XFER:    w_next = w_last ? HOLD : XFER;
      HOLD:    w_next = w_tc ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  // handshake status decodes straight from the state
  always_comb begin
    bus.tx_ready = r_state == IDLE;
    bus.busy     = r_state != IDLE;
  end
  // datapath: counters, shift registers and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus.tx_valid) begin
          r_tx_shift <= bus.tx_data[6:0];
          r_mosi     <= bus.tx_data[7];
          r_cs_n     <= 1'b0;
          r_bit_cnt  <= '0;
          r_div_cnt  <= '0;
        end
        SETUP: r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
        XFER: begin
          r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
          if (w_tc) begin
            r_sclk <= !r_sclk;
            if (!r_sclk) r_rx_shift <= {r_rx_shift[6:0], bus.miso};
            else if (r_bit_cnt != 3'd7) begin
              r_mosi     <= r_tx_shift[6];
              r_tx_shift <= {r_tx_shift[5:0], 1'b0};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
            end else r_mosi <= 1'b0;
          end
        end
        HOLD: begin
          r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
          if (w_tc) begin
            r_cs_n     <= 1'b1;
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign bus.sclk     = r_sclk;
  assign bus.mosi     = r_mosi;
  assign bus.cs_n     = r_cs_n;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: three DUTs (DIV=2,1,3) checked every cycle against a frame-offset model
module tb_spi_master_ctrl;
  localparam int DIVS [3] = '{2, 1, 3};
  typedef struct {
    int         i;
    logic [7:0] tx;
    logic [7:0] s;
    logic [7:0] rx;
    int         len;
  } vec_t;
  logic       clk = 1'b0;
  logic [2:0] rst_v = '1;
  logic [2:0] tv = '0;
  logic [2:0] mi = '0;
  logic [7:0] td [3];
  logic [7:0] sb [3];
  logic [2:0] o_ready, o_busy, o_rxv, o_sclk, o_mosi, o_csn;
  logic [7:0] o_rxd [3];
  int         checks = 0;
  int         errors = 0;
  bit         chk_on = 1'b0;
  bit         act [3] = '{0, 0, 0};
  bit         done [3] = '{0, 0, 0};
  int         k [3] = '{0, 0, 0};
  logic [7:0] mb [3] = '{0, 0, 0};
  logic [7:0] ms [3] = '{0, 0, 0};
  logic [7:0] erxd [3] = '{0, 0, 0};
  int         rc [3] = '{0, 0, 0};
  int         pv [3] = '{0, 0, 0};
  int         hc [3] = '{0, 0, 0};
  int         fc [3] = '{0, 0, 0};
  int         sidx [3] = '{0, 0, 0};
  bit         ps [3] = '{0, 0, 0};
  bit         pcs [3] = '{0, 0, 0};
  logic [7:0] cap [3] = '{0, 0, 0};
  always #5 clk = ~clk;
  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    spi_master_ctrl_if bus ();
    spi_master_ctrl #(.DIV(DIVS[g])) dut (.clk(clk), .rst(rst_v[g]), .bus(bus));
    assign bus.tx_data  = td[g];
    assign bus.tx_valid = tv[g];
    assign bus.miso     = mi[g];
    assign o_ready[g]   = bus.tx_ready;
    assign o_busy[g]    = bus.busy;
    assign o_rxv[g]     = bus.rx_valid;
    assign o_sclk[g]    = bus.sclk;
    assign o_mosi[g]    = bus.mosi;
    assign o_csn[g]     = bus.cs_n;
    assign o_rxd[g]     = bus.rx_data;
  end
  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", nm, i, a, e, $time);
    end
  endtask
  // reference model: a frame is just an offset k from the accept edge
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      done[i] = 1'b0;
      if (rst_v[i]) begin
        act[i]  = 1'b0;
        erxd[i] = 8'h00;
      end else if (act[i]) begin
        k[i]++;
        if (k[i] == 18 * DIVS[i]) begin
          act[i]  = 1'b0;
          done[i] = 1'b1;
          erxd[i] = ms[i];
        end
      end else if (tv[i]) begin
        act[i] = 1'b1;
        k[i]   = 0;
        mb[i]  = td[i];
        ms[i]  = sb[i];
      end
    end
  end
  // slave devices, edge counters and per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      int d, j;
      logic e_sclk, e_mosi;
      d = DIVS[i];
      if (o_sclk[i] === 1'b1 && !ps[i]) begin
        rc[i]++;
        cap[i] = {cap[i][6:0], o_mosi[i]};
      end
      if (o_sclk[i] === 1'b0 && ps[i] && o_csn[i] === 1'b0 && sidx[i] > 0) begin
        sidx[i]--;
        mi[i] = sb[i][sidx[i]];
      end
      if (o_csn[i] === 1'b0 && pcs[i]) begin
        fc[i]++;
        sidx[i] = 7;
        mi[i]   = sb[i][7];
      end
      if (o_rxv[i] === 1'b1) pv[i]++;
      if (o_sclk[i] === 1'b1) hc[i]++;
      ps[i]  = o_sclk[i] === 1'b1;
      pcs[i] = o_csn[i] === 1'b1;
      if (chk_on) begin
        e_sclk = act[i] && k[i] >= 2 * d && k[i] < 17 * d && ((k[i] - 2 * d) / d) % 2 == 0;
        j      = k[i] < 3 * d ? 0 : (k[i] - 3 * d) / (2 * d) + 1;
        e_mosi = act[i] && k[i] < 17 * d ? mb[i][7 - j] : 1'b0;
        chk("m_ready", i, o_ready[i], !act[i]);
        chk("m_busy", i, o_busy[i], act[i]);
        chk("m_cs_n", i, o_csn[i], !act[i]);
        chk("m_sclk", i, o_sclk[i], e_sclk);
        chk("m_mosi", i, o_mosi[i], e_mosi);
        chk("m_rx_valid", i, o_rxv[i], done[i]);
        chk("m_rx_data", i, o_rxd[i], erxd[i]);
      end
    end
  end
  // request a byte and return on the negedge just after the accept edge, tx_valid still high
  task automatic start(input int i, input logic [7:0] tx, input logic [7:0] s);
    int n;
    sb[i] = s;
    td[i] = tx;
    tv[i] = 1'b1;
    n = 0;
    while (o_ready[i] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", i, n < 200, 1);
    @(negedge clk);
  endtask
  task automatic finish_frame(input int i, output int len);
    len = 0;
    while (o_rxv[i] !== 1'b1 && len < 300) begin
      @(negedge clk);
      len++;
    end
  endtask
  task automatic frame(input int i, input logic [7:0] tx, input logic [7:0] s, output int len);
    start(i, tx, s);
    tv[i] = 1'b0;
    finish_frame(i, len);
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its end");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl [6];
    int   len, n, hi, p0, r0, h0, f0;
    logic [7:0] tx, s;
    tbl[0] = '{0, 8'hA5, 8'h3C, 8'h3C, 36};
    tbl[1] = '{1, 8'h01, 8'h5A, 8'h5A, 18};
    tbl[2] = '{2, 8'h81, 8'hFF, 8'hFF, 54};
    tbl[3] = '{2, 8'h7E, 8'h00, 8'h00, 54};
    tbl[4] = '{0, 8'h00, 8'hFF, 8'hFF, 36};
    tbl[5] = '{1, 8'hFF, 8'h80, 8'h80, 18};
    for (int i = 0; i < 3; i++) begin
      td[i] = 8'h00;
      sb[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst_v  = '0;
    chk_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_cs_n", i, o_csn[i], 1);
      chk("rst_sclk", i, o_sclk[i], 0);
      chk("rst_mosi", i, o_mosi[i], 0);
      chk("rst_rx_data", i, o_rxd[i], 8'h00);
      chk("rst_rx_valid", i, o_rxv[i], 0);
      chk("rst_ready", i, o_ready[i], 1);
    end
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("idle_sclk", i, o_sclk[i], 0);
        chk("idle_cs_n", i, o_csn[i], 1);
        chk("idle_rx_valid", i, o_rxv[i], 0);
        chk("idle_ready", i, o_ready[i], 1);
      end
    end
    for (int v = 0; v < 6; v++) begin
      int i;
      i  = tbl[v].i;
      p0 = pv[i];
      r0 = rc[i];
      h0 = hc[i];
      frame(i, tbl[v].tx, tbl[v].s, len);
      chk("vec_len", v, len, tbl[v].len);
      chk("vec_rx_data", v, o_rxd[i], tbl[v].rx);
      chk("vec_cs_n_at_done", v, o_csn[i], 1);
      chk("vec_ready_at_done", v, o_ready[i], 1);
      repeat (2) @(negedge clk);
      chk("vec_mosi_bits", v, cap[i], tbl[v].tx);
      chk("vec_rises", v, rc[i] - r0, 8);
      chk("vec_high_cycles", v, hc[i] - h0, 8 * DIVS[i]);
      chk("vec_rx_pulses", v, pv[i] - p0, 1);
    end
    p0 = pv[1];
    r0 = rc[1];
    start(1, 8'h01, 8'h5A);
    td[1] = 8'hFF;
    n  = 0;
    hi = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (o_csn[1]) hi++;
      else if (hi > 0) break;
    end
    chk("b2b_second_accept", 1, n, 19);
    chk("b2b_cs_n_high", 1, hi, 1);
    tv[1] = 1'b0;
    finish_frame(1, len);
    chk("b2b_len", 1, len, 18);
    chk("b2b_rx_data", 1, o_rxd[1], 8'h5A);
    repeat (2) @(negedge clk);
    chk("b2b_rises", 1, rc[1] - r0, 16);
    chk("b2b_rx_pulses", 1, pv[1] - p0, 2);
    chk("b2b_mosi_bits", 1, cap[1], 8'hFF);
    p0 = pv[0];
    f0 = fc[0];
    start(0, 8'hC3, 8'h96);
    tv[0] = 1'b0;
    repeat (10) @(negedge clk);
    td[0] = 8'h00;
    tv[0] = 1'b1;
    chk("busy_ready", 0, o_ready[0], 0);
    @(negedge clk);
    chk("busy_ready", 0, o_ready[0], 0);
    tv[0] = 1'b0;
    finish_frame(0, len);
    chk("busy_len", 0, len, 25);
    chk("busy_rx_data", 0, o_rxd[0], 8'h96);
    repeat (40) @(negedge clk);
    chk("busy_mosi_bits", 0, cap[0], 8'hC3);
    chk("busy_frames", 0, fc[0] - f0, 1);
    chk("busy_rx_pulses", 0, pv[0] - p0, 1);
    chk("busy_cs_n_after", 0, o_csn[0], 1);
    p0 = pv[0];
    start(0, 8'hA5, 8'h3C);
    tv[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", 0, o_csn[0], 1);
    chk("mid_rst_sclk", 0, o_sclk[0], 0);
    chk("mid_rst_mosi", 0, o_mosi[0], 0);
    chk("mid_rst_rx_data", 0, o_rxd[0], 8'h00);
    chk("mid_rst_busy", 0, o_busy[0], 0);
    rst_v[0] = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_rst_no_rx_valid", 0, pv[0] - p0, 0);
    frame(0, 8'h5C, 8'hE7, len);
    chk("post_rst_len", 0, len, 36);
    chk("post_rst_rx_data", 0, o_rxd[0], 8'hE7);
    repeat (2) @(negedge clk);
    for (int r = 0; r < 30; r++) begin
      int i;
      i  = int'($urandom_range(2));
      tx = 8'($urandom);
      s  = 8'($urandom);
      frame(i, tx, s, len);
      chk("rnd_len", i, len, 18 * DIVS[i]);
      chk("rnd_rx_data", i, o_rxd[i], s);
      repeat (2) @(negedge clk);
      chk("rnd_mosi_bits", i, cap[i], tx);
      repeat ($urandom_range(3)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
